// File: rtl/fp_norm_sequencer.sv
// Multi-cycle FP normalizer: one mantissa shift per cycle until normal, denormal, zero or infinite.
// Optional FP_NORM_INEXACT_EN adds out_inexact for bits lost on right shift or overflow to Inf.
module fp_norm_sequencer #(
  parameter int M = 10,
  parameter int E = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_mant,
  input  logic         in_hidden,
  input  logic         in_ovf,
  input  logic [E-1:0] in_exp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_mant,
  output logic [E-1:0] out_exp,
  output logic         out_zero,
  output logic         out_inf,
  output logic         out_denorm
`ifdef FP_NORM_INEXACT_EN
  ,
  output logic         out_inexact
`endif
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;
  localparam logic [E-1:0] XMAX = '1;
  localparam logic [E-1:0] XONE = E'(1);

  state_e         state_q;
  logic [M+1:0]   w_q;
  logic [E-1:0]   x_q;
  logic           in_ready_q, out_valid_q, zero_q, inf_q, denorm_q;
  logic [M-1:0]   mant_q;
  logic [E-1:0]   exp_q;
  logic [M+1:0]   w_shr;
  logic [E-1:0]   x_inc;
`ifdef FP_NORM_INEXACT_EN
  logic           inexact_q;
`endif

  assign w_shr = w_q >> 1;
  assign x_inc = x_q + XONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      w_q         <= '0;
      x_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      mant_q      <= '0;
      exp_q       <= '0;
      zero_q      <= 1'b0;
      inf_q       <= 1'b0;
      denorm_q    <= 1'b0;
`ifdef FP_NORM_INEXACT_EN
      inexact_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          w_q        <= {in_ovf, in_hidden, in_mant};
          x_q        <= in_exp;
          zero_q     <= 1'b0;
          inf_q      <= 1'b0;
          denorm_q   <= 1'b0;
`ifdef FP_NORM_INEXACT_EN
          inexact_q  <= 1'b0;
`endif
          in_ready_q <= 1'b0;
          state_q    <= NORM;
        end
        NORM: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          if (x_q == XMAX) begin
            mant_q <= w_q[M-1:0];
            exp_q  <= x_q;
          end else if (w_q == '0) begin
            mant_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b1;
          end else if (w_q[M+1]) begin
            // x_q < XMAX here, so the increment cannot wrap
            w_q   <= w_shr;
            x_q   <= x_inc;
            exp_q <= x_inc;
            if (x_inc == XMAX) begin
              mant_q <= '0;
              inf_q  <= 1'b1;
`ifdef FP_NORM_INEXACT_EN
              inexact_q <= w_q[0] | (|w_shr[M-1:0]);
`endif
            end else begin
              mant_q <= w_shr[M-1:0];
`ifdef FP_NORM_INEXACT_EN
              inexact_q <= w_q[0];
`endif
            end
          end else if (w_q[M]) begin
            mant_q <= w_q[M-1:0];
            exp_q  <= x_q;
          end else if (x_q <= XONE) begin
            mant_q   <= w_q[M-1:0];
            exp_q    <= '0;
            denorm_q <= 1'b1;
          end else begin
            w_q         <= w_q << 1;
            x_q         <= x_q - XONE;
            state_q     <= NORM;
            out_valid_q <= 1'b0;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_mant   = mant_q;
  assign out_exp    = exp_q;
  assign out_zero   = zero_q;
  assign out_inf    = inf_q;
  assign out_denorm = denorm_q;
`ifdef FP_NORM_INEXACT_EN
  assign out_inexact = inexact_q;
`endif

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Directed bench for fp_norm_sequencer: arithmetic reference model plus per-cycle output checker.
module tb_fp_norm_sequencer;
  localparam int M = 10;
  localparam int E = 5;
  localparam int XMAX = (1 << E) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_hidden, in_ovf;
  logic [M-1:0] in_mant;
  logic [E-1:0] in_exp;
  logic         out_valid, out_ready;
  logic [M-1:0] out_mant;
  logic [E-1:0] out_exp;
  logic         out_zero, out_inf, out_denorm;
`ifdef FP_NORM_INEXACT_EN
  logic         out_inexact;
`endif

  fp_norm_sequencer #(.M(M), .E(E)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_hidden(in_hidden), .in_ovf(in_ovf), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp),
    .out_zero(out_zero), .out_inf(out_inf), .out_denorm(out_denorm)
`ifdef FP_NORM_INEXACT_EN
    , .out_inexact(out_inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int mant; int ex; bit z; bit inf; bit den; bit inx; int k;
  } res_t;

  int   tests = 0;
  int   fails = 0;
  bit   pend  = 0;
  res_t e;

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Reference: closed-form normalization from the leading-one position.
  function automatic res_t model(input bit ovf, input bit hid, input int mant, input int x);
    res_t r;
    int w, p, need, avail;
    r = '{0, 0, 0, 0, 0, 0, 0};
    w = (int'(ovf) << (M + 1)) + (int'(hid) << M) + mant;
    if (x == XMAX) begin
      r.mant = mant; r.ex = x;
    end else if (w == 0) begin
      r.z = 1;
    end else if (ovf) begin
      r.ex  = x + 1;
      r.inx = w[0];
      if (r.ex == XMAX) begin
        r.inf = 1;
        if (((w >> 1) % (1 << M)) != 0) r.inx = 1;
      end else r.mant = (w >> 1) % (1 << M);
    end else begin
      p = 0;
      for (int i = M; i >= 0; i--) if (((w >> i) & 1) == 1) begin p = i; break; end
      need  = M - p;
      avail = (x > 1) ? x - 1 : 0;
      if (need <= avail) begin
        r.k = need; r.mant = (w << need) % (1 << M); r.ex = x - need;
      end else begin
        r.k = avail; r.mant = (w << avail) % (1 << M); r.den = 1;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset && pend && out_valid) begin
      chk("out_mant", out_mant, e.mant);
      chk("out_exp", out_exp, e.ex);
      chk("out_zero", out_zero, e.z);
      chk("out_inf", out_inf, e.inf);
      chk("out_denorm", out_denorm, e.den);
      chk("in_ready_done", in_ready, 0);
`ifdef FP_NORM_INEXACT_EN
      chk("out_inexact", out_inexact, e.inx);
`endif
    end
  end

  task automatic op(input bit ovf, input bit hid, input int mant, input int x, input int hold);
    int n;
    bit seen;
    e = model(ovf, hid, mant, x);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; in_ovf = ovf; in_hidden = hid; in_mant = mant[M-1:0]; in_exp = x[E-1:0];
    pend = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      chk("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      n++;
      seen = out_valid;
    end
    chk("latency", seen ? n + 1 : -1, 2 + e.k);
    repeat (hold) @(posedge clk);
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0; pend = 0;
    chk("retire_valid", out_valid, 0);
    chk("retire_ready", in_ready, 1);
  endtask

  res_t r;
  initial begin
    reset = 1; in_valid = 0; out_ready = 0; in_ovf = 0; in_hidden = 0; in_mant = '0; in_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mant", out_mant, 0);
    chk("rst_flags", {out_zero, out_inf, out_denorm}, 0);
    reset = 0;

    r = model(0, 0, 'h011, 10);
    chk("pin_shift_k", r.k, 6); chk("pin_shift_mant", r.mant, 'h040); chk("pin_shift_exp", r.ex, 4);
    r = model(0, 0, 'h011, 3);
    chk("pin_den_mant", r.mant, 'h044); chk("pin_den_flag", r.den, 1);
    r = model(1, 1, 'h0E5, 25);
    chk("pin_ovf_mant", r.mant, 'h272); chk("pin_ovf_exp", r.ex, 26); chk("pin_ovf_inx", r.inx, 1);
    r = model(1, 1, 'h0E4, 30);
    chk("pin_inf_exp", r.ex, 31); chk("pin_inf_flag", r.inf, 1); chk("pin_inf_mant", r.mant, 0);

    op(0, 1, 'h0E4, 5, 0);
    op(1, 1, 'h0E5, 25, 0);
    op(1, 1, 'h0E4, 30, 0);
    op(1, 0, 'h0E6, 29, 0);
    op(0, 0, 'h011, 10, 0);
    op(0, 0, 'h011, 3, 0);
    op(0, 0, 'h000, 0, 0);
    op(0, 0, 'h000, 12, 0);
    op(0, 1, 'h155, 31, 0);
    op(1, 0, 'h155, 31, 0);
    op(0, 0, 'h200, 1, 0);
    op(0, 1, 'h000, 0, 0);
    op(0, 0, 'h001, 20, 0);
    op(0, 1, 'h0E4, 5, 5);

    // Abort mid-NORM with async reset
    @(negedge clk);
    in_valid = 1; in_ovf = 0; in_hidden = 0; in_mant = 'h011; in_exp = 10;
    @(posedge clk); #1; in_valid = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk); reset = 0;
    op(0, 0, 'h011, 10, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
